// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, inserts memory wait states and parks in HALT on errors.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] inst,
    input  logic        z,
    input  logic        mem_ready,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        reg2_sel,
    output logic        rf_wr,
    output logic        rf_wr_src,
    output logic [1:0]  seu_src,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  pc_src,
    output logic [1:0]  wr_data_sel,
    output logic        instr_done,
    output logic        halt,
    output logic [1:0]  err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [3:0] K_ILL  = 4'd0;
    localparam logic [3:0] K_R    = 4'd1;
    localparam logic [3:0] K_ADDI = 4'd2;
    localparam logic [3:0] K_SUBI = 4'd3;
    localparam logic [3:0] K_LDUR = 4'd4;
    localparam logic [3:0] K_STUR = 4'd5;
    localparam logic [3:0] K_B    = 4'd6;
    localparam logic [3:0] K_BL   = 4'd7;
    localparam logic [3:0] K_BR   = 4'd8;
    localparam logic [3:0] K_CBZ  = 4'd9;
    localparam logic [3:0] K_CBNZ = 4'd10;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]    r_state;
    logic [1:0]    r_err;
    logic [CW-1:0] r_wait;

    logic [3:0] w_cls;
    logic [3:0] w_rAluOp;
    logic [3:0] w_exAluOp;
    logic [1:0] w_exSeuSrc;
    logic       w_exAluSrcB;
    logic [2:0] w_nextState;
    logic [1:0] w_errCode;
    logic       w_timeout;

    logic       w_irWr, w_pcWr, w_reg2Sel, w_rfWr, w_rfWrSrc, w_aluSrcB;
    logic       w_memRd, w_memWr, w_instrDone, w_halt;
    logic [1:0] w_seuSrc, w_pcSrc, w_wrDataSel;
    logic [3:0] w_aluOp;

    always_comb begin
        w_cls    = K_ILL;
        w_rAluOp = 4'b0000;
        casez (inst)
            11'b10001011000: begin w_cls = K_R; w_rAluOp = 4'b0010; end
            11'b11001011000: begin w_cls = K_R; w_rAluOp = 4'b0110; end
            11'b10001010000: begin w_cls = K_R; w_rAluOp = 4'b0000; end
            11'b10101010000: begin w_cls = K_R; w_rAluOp = 4'b0001; end
            11'b11010011011: begin w_cls = K_R; w_rAluOp = 4'b1000; end
            11'b11010011010: begin w_cls = K_R; w_rAluOp = 4'b1001; end
            11'b1001000100?: w_cls = K_ADDI;
            11'b1101000100?: w_cls = K_SUBI;
            11'b11111000010: w_cls = K_LDUR;
            11'b11111000000: w_cls = K_STUR;
            11'b000101?????: w_cls = K_B;
            11'b100101?????: w_cls = K_BL;
            11'b10110100???: w_cls = K_CBZ;
            11'b10110101???: w_cls = K_CBNZ;
            11'b11010110000: w_cls = K_BR;
            default:         w_cls = K_ILL;
        endcase
    end

    // ALU set-up chosen in EXEC; WB re-drives it so the result stays stable.
    always_comb begin
        w_exAluOp   = 4'b0000;
        w_exSeuSrc  = 2'd0;
        w_exAluSrcB = 1'b0;
        case (w_cls)
            K_R:          w_exAluOp = w_rAluOp;
            K_ADDI:       begin w_exAluOp = 4'b0010; w_exAluSrcB = 1'b1; end
            K_SUBI:       begin w_exAluOp = 4'b0110; w_exAluSrcB = 1'b1; end
            K_LDUR,
            K_STUR:       begin w_exAluOp = 4'b0010; w_exSeuSrc = 2'd1; w_exAluSrcB = 1'b1; end
            K_CBZ,
            K_CBNZ:       begin w_exAluOp = 4'b0111; w_exSeuSrc = 2'd3; end
            default:      ;
        endcase
    end

    assign w_timeout = (r_wait == CW'(MEM_TIMEOUT)) && !mem_ready;

    always_comb begin
        w_nextState = r_state;
        w_errCode   = ERR_NONE;
        w_irWr      = 1'b0;
        w_pcWr      = 1'b0;
        w_reg2Sel   = 1'b0;
        w_rfWr      = 1'b0;
        w_rfWrSrc   = 1'b0;
        w_seuSrc    = 2'd0;
        w_aluSrcB   = 1'b0;
        w_aluOp     = 4'b0000;
        w_memRd     = 1'b0;
        w_memWr     = 1'b0;
        w_pcSrc     = 2'd0;
        w_wrDataSel = 2'd0;
        w_instrDone = 1'b0;
        w_halt      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irWr      = 1'b1;
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                if (w_cls == K_ILL) begin
                    w_nextState = S_HALT;
                    w_errCode   = ERR_ILLEGAL;
                end else begin
                    w_nextState = S_EXEC;
                    w_reg2Sel   = (w_cls == K_STUR) || (w_cls == K_CBZ) ||
                                  (w_cls == K_CBNZ) || (w_cls == K_BR);
                end
            end
            S_EXEC: begin
                w_aluOp   = w_exAluOp;
                w_seuSrc  = w_exSeuSrc;
                w_aluSrcB = w_exAluSrcB;
                case (w_cls)
                    K_R, K_ADDI, K_SUBI: w_nextState = S_WB;
                    K_LDUR, K_STUR:      w_nextState = S_MEM;
                    K_B, K_BL: begin
                        w_seuSrc    = 2'd2;
                        w_pcSrc     = 2'd1;
                        w_pcWr      = 1'b1;
                        w_instrDone = 1'b1;
                        w_nextState = S_FETCH;
                        if (w_cls == K_BL) begin
                            w_rfWr      = 1'b1;
                            w_rfWrSrc   = 1'b1;
                            w_wrDataSel = 2'd2;
                        end
                    end
                    K_BR: begin
                        w_reg2Sel   = 1'b1;
                        w_pcSrc     = 2'd2;
                        w_pcWr      = 1'b1;
                        w_instrDone = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    K_CBZ, K_CBNZ: begin
                        w_reg2Sel   = 1'b1;
                        w_pcWr      = 1'b1;
                        w_instrDone = 1'b1;
                        w_pcSrc     = ((w_cls == K_CBZ) ? z : !z) ? 2'd1 : 2'd0;
                        w_nextState = S_FETCH;
                    end
                    default: begin
                        w_nextState = S_HALT;
                        w_errCode   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                w_seuSrc  = 2'd1;
                w_aluSrcB = 1'b1;
                w_memRd   = (w_cls == K_LDUR);
                w_memWr   = (w_cls == K_STUR);
                if (mem_ready) begin
                    if (w_cls == K_STUR) begin
                        w_pcWr      = 1'b1;
                        w_instrDone = 1'b1;
                        w_nextState = S_FETCH;
                    end else begin
                        w_nextState = S_WB;
                    end
                end else if (w_timeout) begin
                    w_nextState = S_HALT;
                    w_errCode   = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                w_aluOp     = w_exAluOp;
                w_seuSrc    = w_exSeuSrc;
                w_aluSrcB   = w_exAluSrcB;
                w_rfWr      = 1'b1;
                w_wrDataSel = (w_cls == K_LDUR) ? 2'd1 : 2'd0;
                w_pcWr      = 1'b1;
                w_instrDone = 1'b1;
                w_nextState = S_FETCH;
            end
            S_HALT:  w_halt = 1'b1;
            default: w_nextState = S_FETCH;
        endcase
    end

    // Wait counter runs only inside MEM, so leaving MEM is what clears it for the next entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_err   <= ERR_NONE;
            r_wait  <= '0;
        end else begin
            r_state <= w_nextState;
            if ((w_nextState == S_HALT) && (r_state != S_HALT))
                r_err <= w_errCode;
            if (r_state != S_MEM)
                r_wait <= '0;
            else if (!mem_ready)
                r_wait <= r_wait + 1'b1;
        end
    end

    // Gating with rst_n drops any in-flight strobe the moment reset asserts.
    assign {ir_wr, pc_wr, reg2_sel, rf_wr, rf_wr_src, seu_src, alu_src_b, alu_op,
            mem_rd, mem_wr, pc_src, wr_data_sel, instr_done, halt} =
        rst_n ? {w_irWr, w_pcWr, w_reg2Sel, w_rfWr, w_rfWrSrc, w_seuSrc, w_aluSrcB, w_aluOp,
                 w_memRd, w_memWr, w_pcSrc, w_wrDataSel, w_instrDone, w_halt} : 20'd0;

    assign err   = r_err;
    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds the expected per-cycle control sequence of each
// instruction from the opcode table and latency rules, then checks directed and random runs.
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       irWr;
        logic       pcWr;
        logic       reg2Sel;
        logic       rfWr;
        logic       rfWrSrc;
        logic [1:0] seuSrc;
        logic       aluSrcB;
        logic [3:0] aluOp;
        logic       memRd;
        logic       memWr;
        logic [1:0] pcSrc;
        logic [1:0] wrDataSel;
        logic       instrDone;
        logic       halt;
        logic [1:0] err;
    } ctrl_t;

    typedef enum int {C_ILL, C_R, C_ADDI, C_SUBI, C_LD, C_ST, C_B, C_BL, C_BR, C_CBZ, C_CBNZ} cls_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] inst = '0;
    logic        z = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_wr, pc_wr, reg2_sel, rf_wr, rf_wr_src, alu_src_b;
    logic        mem_rd, mem_wr, instr_done, halt;
    logic [1:0]  seu_src, pc_src, wr_data_sel, err;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .z(z), .mem_ready(mem_ready),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .reg2_sel(reg2_sel), .rf_wr(rf_wr),
        .rf_wr_src(rf_wr_src), .seu_src(seu_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_src(pc_src),
        .wr_data_sel(wr_data_sel), .instr_done(instr_done), .halt(halt),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;

    ctrl_t actVec;
    assign actVec = {state, ir_wr, pc_wr, reg2_sel, rf_wr, rf_wr_src, seu_src, alu_src_b,
                     alu_op, mem_rd, mem_wr, pc_src, wr_data_sel, instr_done, halt, err};

    int    compared = 0;
    int    mismatched = 0;
    logic [1:0] modelErr = 2'd0;

    // Running activity totals; directed tests take differences around one instruction.
    int    totCycles = 0, totRfWr = 0, totPcWr = 0, totDone = 0, totMemRd = 0, totMemWr = 0;
    ctrl_t lastExecVec = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            totCycles++;
            if (rf_wr)      totRfWr++;
            if (pc_wr)      totPcWr++;
            if (instr_done) totDone++;
            if (mem_rd)     totMemRd++;
            if (mem_wr)     totMemWr++;
            if (state == 3'd2) lastExecVec = actVec;
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cls_e classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
            op == 11'b10101010000 || op == 11'b11010011011 || op == 11'b11010011010) return C_R;
        if ((op & 11'b11111111110) == 11'b10010001000) return C_ADDI;
        if ((op & 11'b11111111110) == 11'b11010001000) return C_SUBI;
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if ((op & 11'b11111100000) == 11'b00010100000) return C_B;
        if ((op & 11'b11111100000) == 11'b10010100000) return C_BL;
        if ((op & 11'b11111111000) == 11'b10110100000) return C_CBZ;
        if ((op & 11'b11111111000) == 11'b10110101000) return C_CBNZ;
        if (op == 11'b11010110000) return C_BR;
        return C_ILL;
    endfunction

    function automatic logic [3:0] rAluOp(input logic [10:0] op);
        case (op)
            11'b10001011000: return 4'b0010;
            11'b11001011000: return 4'b0110;
            11'b10001010000: return 4'b0000;
            11'b10101010000: return 4'b0001;
            11'b11010011011: return 4'b1000;
            11'b11010011010: return 4'b1001;
            default:         return 4'b0000;
        endcase
    endfunction

    function automatic ctrl_t withAlu(input ctrl_t e, input cls_e c, input logic [10:0] op);
        ctrl_t r = e;
        case (c)
            C_R:          r.aluOp = rAluOp(op);
            C_ADDI:       begin r.aluOp = 4'b0010; r.aluSrcB = 1'b1; end
            C_SUBI:       begin r.aluOp = 4'b0110; r.aluSrcB = 1'b1; end
            C_LD, C_ST:   begin r.aluOp = 4'b0010; r.seuSrc = 2'd1; r.aluSrcB = 1'b1; end
            C_CBZ, C_CBNZ: begin r.aluOp = 4'b0111; r.seuSrc = 2'd3; end
            default:      ;
        endcase
        return r;
    endfunction

    function automatic logic [10:0] randOp(input int pick);
        logic [10:0] r = 11'($urandom);
        case (pick)
            0:  return 11'b10001011000;
            1:  return 11'b11001011000;
            2:  return 11'b10001010000;
            3:  return 11'b10101010000;
            4:  return 11'b11010011011;
            5:  return 11'b11010011010;
            6:  return {10'b1001000100, r[0]};
            7:  return {10'b1101000100, r[0]};
            8:  return 11'b11111000010;
            9:  return 11'b11111000000;
            10: return {6'b000101, r[4:0]};
            11: return {6'b100101, r[4:0]};
            12: return {8'b10110100, r[2:0]};
            13: return {8'b10110101, r[2:0]};
            14: return 11'b11010110000;
            default: return r;
        endcase
    endfunction

    // One clock cycle: drive inputs just after the edge, compare on the falling edge.
    task automatic driveCycle(input ctrl_t e, input string nm, input logic zv, input logic rdy);
        z = zv;
        mem_ready = rdy;
        @(negedge clk);
        checkOutput(nm, 32'(actVec), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic haltPhase(input int n);
        ctrl_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.st = 3'd7;
            e.halt = 1'b1;
            e.err = modelErr;
            driveCycle(e, "halt", 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic applyReset;
        rst_n = 1'b0;
        #1;
        checkOutput("resetZero", 32'(actVec), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelErr = 2'd0;
    endtask

    // Runs one instruction. waits = MEM cycles with mem_ready low before it rises;
    // abortK >= 0 pulses reset in that MEM cycle instead of completing.
    task automatic applyStimulus(input logic [10:0] op, input logic zExec, input int waits,
                                 input int abortK, input int haltCycles);
        cls_e  c = classify(op);
        ctrl_t e;
        logic  rdy;
        inst = op;

        e = '0; e.st = 3'd0; e.irWr = 1'b1;
        driveCycle(e, "fetch", 1'($urandom), 1'($urandom));

        e = '0; e.st = 3'd1;
        if (c == C_ILL) begin
            driveCycle(e, "decodeIllegal", 1'($urandom), 1'($urandom));
            modelErr = 2'd1;
            haltPhase(haltCycles);
            return;
        end
        e.reg2Sel = (c == C_ST || c == C_CBZ || c == C_CBNZ || c == C_BR);
        driveCycle(e, "decode", 1'($urandom), 1'($urandom));

        e = '0; e.st = 3'd2;
        case (c)
            C_B, C_BL: begin
                e.seuSrc = 2'd2; e.pcSrc = 2'd1; e.pcWr = 1'b1; e.instrDone = 1'b1;
                if (c == C_BL) begin e.rfWr = 1'b1; e.rfWrSrc = 1'b1; e.wrDataSel = 2'd2; end
            end
            C_BR: begin
                e.reg2Sel = 1'b1; e.pcSrc = 2'd2; e.pcWr = 1'b1; e.instrDone = 1'b1;
            end
            C_CBZ, C_CBNZ: begin
                e = withAlu(e, c, op);
                e.reg2Sel = 1'b1; e.pcWr = 1'b1; e.instrDone = 1'b1;
                e.pcSrc = (((c == C_CBZ) && zExec) || ((c == C_CBNZ) && !zExec)) ? 2'd1 : 2'd0;
            end
            default: e = withAlu(e, c, op);
        endcase
        driveCycle(e, "exec", zExec, 1'($urandom));
        if (e.instrDone) return;

        if (c == C_LD || c == C_ST) begin
            for (int k = 0; k <= MEM_TIMEOUT; k++) begin
                e = '0; e.st = 3'd3; e.seuSrc = 2'd1; e.aluSrcB = 1'b1;
                e.memRd = (c == C_LD);
                e.memWr = (c == C_ST);
                if (k == abortK) begin
                    z = 1'($urandom);
                    mem_ready = 1'b0;
                    @(negedge clk);
                    checkOutput("memPreAbort", 32'(actVec), 32'(e));
                    #2;
                    rst_n = 1'b0;
                    #1;
                    checkOutput("abortZero", 32'(actVec), 32'd0);
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    modelErr = 2'd0;
                    return;
                end
                rdy = (k == waits);
                if (rdy && c == C_ST) begin
                    e.pcWr = 1'b1; e.instrDone = 1'b1;
                    driveCycle(e, "memStoreDone", 1'($urandom), rdy);
                    return;
                end
                if (!rdy && k == MEM_TIMEOUT) begin
                    driveCycle(e, "memTimeout", 1'($urandom), rdy);
                    modelErr = 2'd2;
                    haltPhase(haltCycles);
                    return;
                end
                driveCycle(e, "mem", 1'($urandom), rdy);
                if (rdy) break;
            end
        end

        e = '0; e.st = 3'd4;
        e = withAlu(e, c, op);
        e.rfWr = 1'b1; e.pcWr = 1'b1; e.instrDone = 1'b1;
        e.wrDataSel = (c == C_LD) ? 2'd1 : 2'd0;
        driveCycle(e, "wb", 1'($urandom), 1'($urandom));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, rf0, pc0, dn0, mr0, mw0;
        int waits, abortK, r;
        #2;
        applyReset();

        // ADD straight out of reset
        c0 = totCycles; rf0 = totRfWr; pc0 = totPcWr; dn0 = totDone;
        applyStimulus(11'b10001011000, 1'b0, 0, -1, 0);
        checkOutput("addCycles", 32'(totCycles - c0), 32'd4);
        checkOutput("addRfWr",   32'(totRfWr - rf0),  32'd1);
        checkOutput("addPcWr",   32'(totPcWr - pc0),  32'd1);
        checkOutput("addDone",   32'(totDone - dn0),  32'd1);

        // LDUR with two wait states
        c0 = totCycles; mr0 = totMemRd;
        applyStimulus(11'b11111000010, 1'b0, 2, -1, 0);
        checkOutput("ldurCycles", 32'(totCycles - c0), 32'd7);
        checkOutput("ldurMemRd",  32'(totMemRd - mr0), 32'd3);

        // CBZ taken then not taken
        c0 = totCycles; pc0 = totPcWr;
        applyStimulus(11'b10110100000, 1'b1, 0, -1, 0);
        checkOutput("cbzTakenSrc", 32'(lastExecVec.pcSrc), 32'd1);
        checkOutput("cbzTakenCycles", 32'(totCycles - c0), 32'd3);
        c0 = totCycles;
        applyStimulus(11'b10110100101, 1'b0, 0, -1, 0);
        checkOutput("cbzNotSrc", 32'(lastExecVec.pcSrc), 32'd0);
        checkOutput("cbzNotCycles", 32'(totCycles - c0), 32'd3);
        checkOutput("cbzPcWr", 32'(totPcWr - pc0), 32'd2);

        // BL link controls in EXEC: rfWr, rfWrSrc, wrDataSel, pcSrc, seuSrc
        applyStimulus(11'b10010100011, 1'b0, 0, -1, 0);
        checkOutput("blExec", {24'd0, lastExecVec.rfWr, lastExecVec.rfWrSrc,
                     lastExecVec.wrDataSel, lastExecVec.pcSrc, lastExecVec.seuSrc}, 32'hE6);

        // STUR answered exactly at the timeout boundary still succeeds
        c0 = totCycles; dn0 = totDone;
        applyStimulus(11'b11111000000, 1'b0, MEM_TIMEOUT, -1, 0);
        checkOutput("sturBoundaryCycles", 32'(totCycles - c0), 32'(4 + MEM_TIMEOUT));
        checkOutput("sturBoundaryDone", 32'(totDone - dn0), 32'd1);

        // STUR never answered: timeout into HALT
        rf0 = totRfWr; pc0 = totPcWr; mw0 = totMemWr;
        applyStimulus(11'b11111000000, 1'b0, MEM_TIMEOUT + 1, -1, 4);
        checkOutput("timeoutMemWr", 32'(totMemWr - mw0), 32'(MEM_TIMEOUT + 1));
        checkOutput("timeoutRfWr", 32'(totRfWr - rf0), 32'd0);
        checkOutput("timeoutPcWr", 32'(totPcWr - pc0), 32'd0);
        checkOutput("timeoutHaltErr", {29'd0, halt, err}, 32'h6);
        applyReset();

        // Illegal opcode, reset, then reset again in the middle of a store
        applyStimulus(11'b00000000000, 1'b0, 0, -1, 3);
        checkOutput("illegalHaltErr", {29'd0, halt, err}, 32'h5);
        applyReset();
        checkOutput("postResetStateErr", {27'd0, state, err}, 32'd0);
        dn0 = totDone;
        applyStimulus(11'b11111000000, 1'b0, 5, 2, 0);
        checkOutput("abortNoDone", 32'(totDone - dn0), 32'd0);

        // Randomized instruction stream
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       waits = $urandom_range(0, 4);
            else if (r == 7) waits = MEM_TIMEOUT;
            else if (r == 8) waits = MEM_TIMEOUT + 1;
            else             waits = $urandom_range(5, 14);
            abortK = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            applyStimulus(randOp($urandom_range(0, 16)), 1'($urandom), waits, abortK, 2);
            if (modelErr != 2'd0) applyReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
